// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scheduler.
package disp_pkg;

  localparam int unsigned NSRC = 4;
  localparam int unsigned DW   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  localparam logic [3:0] AN_D0 = 4'b1110;
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D3 = 4'b0111;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } pick_t;

  // Round-robin pick: first set request bit searching from rr+1 upward, mod 4.
  function automatic pick_t rr_pick(input logic [NSRC-1:0] req, input logic [1:0] rr);
    pick_t      p;
    logic [1:0] i;
    p = '0;
    // Descending offsets so the lowest offset (closest to rr+1) is written last.
    for (int off = NSRC; off >= 1; off--) begin
      i = rr + 2'(off);
      if (req[i]) begin
        p.hit = 1'b1;
        p.idx = i;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/disp_scheduler_scan_tick_gen.sv
// Digit-scan timing: slot divider, 0..3 digit counter and end-of-frame pulse.
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 400000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [1:0] digit_o,
  output logic       frame_done_o
);

  localparam int unsigned CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt_q;
  logic [1:0]    digit_q;
  logic          fd_q;
  logic          tick;

  assign tick = (cnt_q == CW'(SCAN_DIV - 1));

  // frame_done is registered, so it is high in the first cycle of digit 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      digit_q <= '0;
      fd_q    <= 1'b0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
      if (tick) digit_q <= digit_q + 2'd1;
      fd_q  <= tick && (digit_q == 2'd3);
    end
  end

  assign digit_o      = digit_q;
  assign frame_done_o = fd_q;

endmodule

// File: rtl/disp_scheduler.sv
// Round-robin sharing of a 4-digit 7-segment display between four 16-bit sources,
// with per-source minimum hold and frame-aligned value snapshots.
module disp_scheduler
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 400000,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic                Sclk,
  input  logic                rst,
  input  logic [NSRC-1:0]     req,
  input  logic [NSRC*DW-1:0]  src_data,
  output logic [NSRC-1:0]     grant,
  output logic [DW-1:0]       disp_val,
  output logic [3:0]          nibble,
  output logic [1:0]          digit,
  output logic [3:0]          an_n,
  output logic                frame_done,
  output logic                busy
);

  localparam int unsigned HW = $clog2(HOLD_FRAMES) + 1;

  state_e          state_q;
  logic [NSRC-1:0] grant_q;
  logic [DW-1:0]   val_q;
  logic [1:0]      rr_q;
  logic [HW-1:0]   hold_q;
  logic            busy_q;

  pick_t           pick;
  logic            cur_req;
  logic            expire;
  logic [DW-1:0]   cur_data;
  logic [DW-1:0]   pick_data;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk_i        (Sclk),
    .rst_i        (rst),
    .digit_o      (digit),
    .frame_done_o (frame_done)
  );

  // While in SHOW, rr_q always holds the granted source index.
  assign pick      = rr_pick(req, rr_q);
  assign cur_req   = req[rr_q];
  assign cur_data  = src_data[{rr_q, 4'b0000} +: DW];
  assign pick_data = src_data[{pick.idx, 4'b0000} +: DW];
  assign expire    = (hold_q == HW'(HOLD_FRAMES - 1)) || !cur_req;

  // Arbitration FSM and snapshot register; all decisions on frame boundaries only.
  always_ff @(posedge Sclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      val_q   <= '0;
      rr_q    <= 2'd3;
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else if (frame_done) begin
      case (state_q)
        IDLE: begin
          if (pick.hit) begin
            state_q <= SHOW;
            grant_q <= 4'b0001 << pick.idx;
            val_q   <= pick_data;
            rr_q    <= pick.idx;
            hold_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        SHOW: begin
          if (!expire) begin
            hold_q <= hold_q + HW'(1);
            val_q  <= cur_data;
          end else if (!pick.hit) begin
            state_q <= IDLE;
            grant_q <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
          end else begin
            grant_q <= 4'b0001 << pick.idx;
            val_q   <= pick_data;
            rr_q    <= pick.idx;
            hold_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Digit mux toward the hex-to-segment decoder; digit 0 is the leftmost (MS nibble).
  always_comb begin
    nibble = val_q[15:12];
    an_n   = AN_D0;
    case (digit)
      2'd0: begin nibble = val_q[15:12]; an_n = AN_D0; end
      2'd1: begin nibble = val_q[11:8];  an_n = AN_D1; end
      2'd2: begin nibble = val_q[7:4];   an_n = AN_D2; end
      2'd3: begin nibble = val_q[3:0];   an_n = AN_D3; end
      default: begin nibble = val_q[15:12]; an_n = AN_D0; end
    endcase
  end

  assign grant    = grant_q;
  assign disp_val = val_q;
  assign busy     = busy_q;

endmodule

// File: doc/disp_scheduler.md
Name: disp_scheduler

Overview:
Shares the 4-digit multiplexed 7-segment display between up to four 16-bit requesters, such as the ALU result, PC, instruction and register readout. It generates the digit-scan timing and arbitrates round-robin with a minimum hold time per source. It snapshots the granted value at frame boundaries, so a digit never tears mid-frame. Its outputs feed the existing hex-to-segment decoder: nibble, active-low anodes and digit index.

Parameters:
SCAN_DIV, 400000, Sclk cycles per digit slot (≥2)
HOLD_FRAMES, 8, full 4-digit frames a granted source is held before re-arbitration (≥1)

Ports:
Sclk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req  input  4  per-source display request; bit i = source i
src_data  input  64  source i value at bits [16i+15:16i]
grant  output  4  one-hot grant, all-zero when idle
disp_val  output  16  snapshot value currently shown
nibble  output  4  nibble for active digit, to segment decoder
digit  output  2  active digit index, 0 = leftmost
an_n  output  4  active-low anode enables
frame_done  output  1  one-cycle pulse at end of digit 3 slot
busy  output  1  high while in SHOW

Behaviour:
- Reset (async, any cycle, incl. mid-hold):
  - divider counter = 0, digit = 0, an_n = 1110;
  - disp_val = 0, grant = 0000, state = IDLE, hold_cnt = 0;
  - rr pointer = 3, so source 0 wins first;
  - frame_done = 0, busy = 0.
- Scan timing:
  - Divider counts 0..SCAN_DIV-1; tick = (counter == SCAN_DIV-1); counter wraps to 0 on tick.
  - Digit increments on tick and wraps 3→0; no digit-4 state.
  - frame_done = tick && digit == 3, registered, so it pulses the cycle digit returns to 0.
- Digit mapping, combinational from digit and disp_val:
  - 0: [15:12], an_n 1110
  - 1: [11:8], an_n 1101
  - 2: [7:4], an_n 1011
  - 3: [3:0], an_n 0111
- Scanning runs in every state; IDLE keeps showing the last disp_val.
- State IDLE:
  - Leaves only on a frame boundary: the cycle frame_done is asserted, with req != 0.
  - Winner = first set req bit searching from rr+1 upward, mod 4.
  - Next cycle: grant = one-hot winner, disp_val = src_data of winner, rr = winner, hold_cnt = 0 → SHOW.
- State SHOW:
  - grant is held stable; disp_val is re-sampled from the granted source on each frame_done only, never mid-frame.
  - On frame_done with hold_cnt < HOLD_FRAMES-1: hold_cnt++.
  - On frame_done with hold_cnt == HOLD_FRAMES-1, re-arbitrate from rr+1:
    - another requester wins → switch grant, load its data, hold_cnt = 0;
    - only the current source requests → keep grant, hold_cnt = 0;
    - req == 0 → grant = 0, IDLE, disp_val keeps its last value.
  - Granted req drops before hold expires:
    - hold_cnt is forced to expire at the next frame_done;
    - the current frame completes first, showing the last snapshot.
- Simultaneous events:
  - New requests and req drops landing on the same frame_done cycle are evaluated on that cycle's req sample.
- Latency:
  - Request-to-display ≤ one frame (4·SCAN_DIV cycles) from IDLE.
  - Worst case HOLD_FRAMES·3+1 frames under full contention.
- Widths: hold_cnt is clog2(HOLD_FRAMES)+1 bits; divider is clog2(SCAN_DIV) bits; no overflow is possible.

Decomposition:
- Package disp_pkg:
  - state encoding IDLE/SHOW;
  - anode pattern constants AN_D0..AN_D3 (1110, 1101, 1011, 0111);
  - NSRC = 4.
- Sub-module scan_tick_gen: divider, digit counter and frame_done, parameterised by SCAN_DIV.
- Arbitration FSM, snapshot register and digit mux stay in disp_scheduler.

Test Plan (SCAN_DIV=4, HOLD_FRAMES=2, frame = 16 cycles):
- Reset, no req → digit cycles 0,1,2,3,0 every 4 clocks; an_n follows 1110,1101,1011,0111; frame_done pulses every 16 clocks; grant=0000; nibble=0.
- req=0001, src0=16'h1A2F → at first frame_done: grant=0001, busy=1, disp_val=1A2F; nibble sequence 1,A,2,F across next frame.
- req=0101, src0=1111, src2=2222 → grant 0001 for 2 frames, then 0100 for 2 frames, then 0001; disp_val alternates 1111/2222.
- src0 changes 1111→3333 mid-frame while granted → nibble stays 1 until frame_done, next frame shows 3333.
- Granted req drops at hold_cnt=0 with req=0000 → at next frame_done grant=0000, busy=0, disp_val holds previous value.
- rst asserted mid-SHOW at digit 2 → same cycle: grant=0000, an_n=1110, disp_val=0000; after release, src0 wins first.
